// File: rtl/event_monitor_mc_if.sv
// Event drain interface of event_monitor_mc.
//
// Handshake: evt_valid is high while the event FIFO holds at least one
// record, and evt_data always shows the head record (show-ahead; zero when
// empty). The consumer pulses evt_pop for one cycle per record it takes; the
// head is removed on the rising edge where evt_pop && evt_valid. A pop while
// evt_valid is low is ignored.
//
// Signals:
//   evt_pop    consumer -> monitor   remove the head record
//   evt_data   monitor  -> consumer  head record {ts, ch_idx, probe_id, probe_data}
//   evt_valid  monitor  -> consumer  FIFO non-empty
interface event_monitor_mc_if #(
  parameter int EVT_W = 74
) ();
  logic             evt_pop;
  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;

  modport master (input evt_pop, output evt_data, output evt_valid);
  modport slave  (output evt_pop, input evt_data, input evt_valid);
endinterface

// File: rtl/event_monitor_mc.sv
// Multi-channel event monitor.
//
// Each channel compares its masked probe bus against a shared masked value
// using one of four trigger modes. While the capture session is ARMED a hit
// is timestamped into a one-entry pending slot per channel; a round-robin
// arbiter moves one pending slot per cycle into a shared show-ahead FIFO.
// The session auto-disarms (DONE) after cap_limit accepted records.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   en                gates timestamp increment and trigger evaluation
//   arm, disarm       session control pulses (disarm wins)
//   clear_sticky      clears sticky flags and drop_count
//   ch_enable         per-channel enable
//   trig_mode         per-channel 2-bit mode, channel i at [2i+1:2i]
//   trig_value/mask   shared compare value and mask
//   cap_limit         accepted-record budget, 0 = unlimited
//   probe_id/data     per-channel probe ID and probe bus
//   evt               drain interface (master side)
//   state             0 IDLE, 1 ARMED, 2 DONE
//   *_sticky          triggered / FIFO overflow / pending-slot loss flags
//   drop_count        saturating count of dropped hits
//   fifo_count        FIFO occupancy
module event_monitor_mc #(
  parameter int NUM_CH     = 4,
  parameter int PROBE_W    = 32,
  parameter int ID_W       = 8,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EVT_W     = TS_W + CH_W + ID_W + PROBE_W,
  localparam int FC_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      arm,
  input  logic                      disarm,
  input  logic                      clear_sticky,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [2*NUM_CH-1:0]       trig_mode,
  input  logic [PROBE_W-1:0]        trig_value,
  input  logic [PROBE_W-1:0]        trig_mask,
  input  logic [CNT_W-1:0]          cap_limit,
  input  logic [ID_W*NUM_CH-1:0]    probe_id,
  input  logic [PROBE_W*NUM_CH-1:0] probe_data,
  event_monitor_mc_if.master        evt,
  output logic [1:0]                state,
  output logic                      triggered_sticky,
  output logic                      overflow_sticky,
  output logic                      lost_sticky,
  output logic [CNT_W-1:0]          drop_count,
  output logic [FC_W-1:0]           fifo_count
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int DS_W = CNT_W + 1;
  localparam int DI_W = $clog2(NUM_CH + 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [TS_W-1:0]                ts_q;
  logic [PROBE_W-1:0]             mv;
  logic [NUM_CH-1:0][PROBE_W-1:0] mp, mp_d;
  logic [NUM_CH-1:0]              match, hit;

  logic [NUM_CH-1:0]  pend_q;
  logic [TS_W-1:0]    slot_ts   [NUM_CH];
  logic [ID_W-1:0]    slot_id   [NUM_CH];
  logic [PROBE_W-1:0] slot_data [NUM_CH];
  logic [NUM_CH-1:0]  lost_vec;

  logic [CH_W-1:0]   rr_q, gnt_idx;
  logic              gnt_any;
  logic [NUM_CH-1:0] gnt;
  logic              clear_pend, arm_entry;

  logic [EVT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [FC_W-1:0]  count_q;
  logic             full, empty, pop_eff, push, ovf_ev;
  logic [EVT_W-1:0] gnt_rec;

  logic [CNT_W-1:0] acc_q;
  logic             cap_hit;
  logic [DI_W-1:0]  drop_inc;
  logic [DS_W-1:0]  drop_sum;
  logic [CNT_W-1:0] drop_d;

  // ---------------- trigger evaluation ----------------
  assign mv = trig_value & trig_mask;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mp[i] = probe_data[i*PROBE_W +: PROBE_W] & trig_mask;
      case (trig_mode[2*i +: 2])
        2'd0:    match[i] = (mp[i] == mv);
        2'd1:    match[i] = (mp_d[i] == '0) && (mp[i] != '0);
        2'd2:    match[i] = (mp[i] != mp_d[i]);
        default: match[i] = (mp[i] > mv);
      endcase
    end
  end

  assign hit = {NUM_CH{en && (state_q == ST_ARMED)}} & ch_enable & match;

  // Previous masked probe is tracked every cycle, independent of en.
  always_ff @(posedge clk) begin
    if (!rst_n) mp_d <= '0;
    else        mp_d <= mp;
  end

  // ---------------- session control ----------------
  // Only a fresh session (from IDLE) discards stale pending slots; re-arming
  // from DONE lets leftover slots keep draining.
  assign arm_entry  = arm && !disarm && (state_q != ST_ARMED);
  assign clear_pend = arm && !disarm && (state_q == ST_IDLE);
  assign cap_hit    = (cap_limit != '0) &&
                      (({1'b0, acc_q} + DS_W'(1)) >= {1'b0, cap_limit});

  always_comb begin
    state_d = state_q;
    if (disarm)                                    state_d = ST_IDLE;
    else if (arm && state_q != ST_ARMED)           state_d = ST_ARMED;
    else if (state_q == ST_ARMED && push && cap_hit) state_d = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                             acc_q <= '0;
    else if (arm_entry)                     acc_q <= '0;
    else if (state_q == ST_ARMED && push)   acc_q <= acc_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)  ts_q <= '0;
    else if (en) ts_q <= ts_q + TS_W'(1);
  end

  // ---------------- round-robin arbiter ----------------
  // Search starts one past the last granted channel. A grant is withheld in
  // the cycle a fresh session clears the slots.
  always_comb begin
    logic [CH_W:0] c;
    gnt_any = 1'b0;
    gnt_idx = '0;
    c       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = {1'b0, rr_q} + (CH_W+1)'(k);
      if (c >= (CH_W+1)'(NUM_CH)) c = c - (CH_W+1)'(NUM_CH);
      if (!gnt_any && !clear_pend && pend_q[c[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = c[CH_W-1:0];
      end
    end
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       rr_q <= CH_W'(NUM_CH - 1);
    else if (gnt_any) rr_q <= gnt_idx;
  end

  // ---------------- pending slots ----------------
  // A slot granted this cycle is free at the edge, so a same-cycle hit
  // reloads it instead of being lost.
  assign lost_vec = hit & pend_q & ~gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clear_pend)                  pend_q[i] <= 1'b0;
        else if (hit[i] && !lost_vec[i]) pend_q[i] <= 1'b1;
        else if (gnt[i])                 pend_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (hit[i] && !lost_vec[i]) begin
        slot_ts[i]   <= ts_q;
        slot_id[i]   <= probe_id[i*ID_W +: ID_W];
        slot_data[i] <= probe_data[i*PROBE_W +: PROBE_W];
      end
    end
  end

  assign gnt_rec = {slot_ts[gnt_idx], gnt_idx, slot_id[gnt_idx], slot_data[gnt_idx]};

  // ---------------- event FIFO ----------------
  assign full    = (count_q == FC_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop_eff = evt.evt_pop && !empty;
  assign push    = gnt_any && (!full || pop_eff);
  assign ovf_ev  = gnt_any && !push;

  always_ff @(posedge clk) begin
    if (rst_n && push) mem[wr_ptr] <= gnt_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop_eff) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop_eff})
        2'b10:   count_q <= count_q + FC_W'(1);
        2'b01:   count_q <= count_q - FC_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt.evt_data  = empty ? '0 : mem[rd_ptr];
  assign evt.evt_valid = !empty;

  // ---------------- sticky flags and drop counter ----------------
  // Several channels can lose a hit in the same cycle as an overflow, so the
  // increment is a population count, then saturated.
  always_comb begin
    drop_inc = DI_W'(ovf_ev);
    for (int i = 0; i < NUM_CH; i++) drop_inc = drop_inc + DI_W'(lost_vec[i]);
    drop_sum = {1'b0, drop_count} + DS_W'(drop_inc);
    drop_d   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_sticky) begin
      triggered_sticky <= 1'b0;
      overflow_sticky  <= 1'b0;
      lost_sticky      <= 1'b0;
      drop_count       <= '0;
    end else begin
      triggered_sticky <= triggered_sticky | push;
      overflow_sticky  <= overflow_sticky | ovf_ev;
      lost_sticky      <= lost_sticky | (|lost_vec);
      drop_count       <= drop_d;
    end
  end

  assign state      = state_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_event_monitor_mc.sv
module tb_event_monitor_mc;
  localparam int NUM_CH     = 4;
  localparam int PROBE_W    = 32;
  localparam int ID_W       = 8;
  localparam int TS_W       = 32;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;
  localparam int CH_W       = 2;
  localparam int EVT_W      = TS_W + CH_W + ID_W + PROBE_W;
  localparam int FC_W       = 5;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst_n, en, arm, disarm, clear_sticky;
  logic [NUM_CH-1:0]         ch_enable;
  logic [2*NUM_CH-1:0]       trig_mode;
  logic [PROBE_W-1:0]        trig_value, trig_mask;
  logic [CNT_W-1:0]          cap_limit;
  logic [ID_W*NUM_CH-1:0]    probe_id;
  logic [PROBE_W*NUM_CH-1:0] probe_data;
  logic [1:0]                state;
  logic                      triggered_sticky, overflow_sticky, lost_sticky;
  logic [CNT_W-1:0]          drop_count;
  logic [FC_W-1:0]           fifo_count;

  event_monitor_mc_if #(.EVT_W(EVT_W)) evt_bus ();

  event_monitor_mc #(
    .NUM_CH(NUM_CH), .PROBE_W(PROBE_W), .ID_W(ID_W), .TS_W(TS_W),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .arm(arm), .disarm(disarm),
    .clear_sticky(clear_sticky), .ch_enable(ch_enable), .trig_mode(trig_mode),
    .trig_value(trig_value), .trig_mask(trig_mask), .cap_limit(cap_limit),
    .probe_id(probe_id), .probe_data(probe_data), .evt(evt_bus),
    .state(state), .triggered_sticky(triggered_sticky),
    .overflow_sticky(overflow_sticky), .lost_sticky(lost_sticky),
    .drop_count(drop_count), .fifo_count(fifo_count)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int               m_state, m_acc, m_rr, m_drop;
  logic [TS_W-1:0]  m_ts;
  bit               m_trig, m_ovf, m_lost;
  bit               m_pend [NUM_CH];
  logic [EVT_W-1:0] m_slot [NUM_CH];
  logic [PROBE_W-1:0] m_mpd [NUM_CH];
  logic [EVT_W-1:0] exp_q[$];

  task automatic model_step();
    logic [PROBE_W-1:0] mv;
    logic [PROBE_W-1:0] mp [NUM_CH];
    bit hit [NUM_CH];
    int g, c, drops, nstate;
    bit pop_ok, push, clr, lost_ev;
    if (!rst_n) begin
      m_state = 0; m_ts = '0; m_trig = 0; m_ovf = 0; m_lost = 0;
      m_drop = 0; m_acc = 0; m_rr = NUM_CH - 1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = 0;
        m_mpd[i]  = '0;
      end
      exp_q.delete();
      return;
    end
    mv = trig_value & trig_mask;
    for (int i = 0; i < NUM_CH; i++) begin
      mp[i] = probe_data[i*PROBE_W +: PROBE_W] & trig_mask;
      case (trig_mode[2*i +: 2])
        2'd0:    hit[i] = (mp[i] == mv);
        2'd1:    hit[i] = (m_mpd[i] == 0) && (mp[i] != 0);
        2'd2:    hit[i] = (mp[i] != m_mpd[i]);
        default: hit[i] = (mp[i] > mv);
      endcase
      hit[i] = hit[i] && en && ch_enable[i] && (m_state == 1);
    end
    clr = (m_state == 0) && arm && !disarm;
    g = -1;
    if (!clr) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        c = (m_rr + k) % NUM_CH;
        if (g < 0 && m_pend[c]) g = c;
      end
    end
    pop_ok = evt_bus.evt_pop && (exp_q.size() > 0);
    push   = (g >= 0) && ((exp_q.size() < FIFO_DEPTH) || pop_ok);
    drops  = ((g >= 0) && !push) ? 1 : 0;
    if (pop_ok) void'(exp_q.pop_front());
    if (push) exp_q.push_back(m_slot[g]);
    lost_ev = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr) m_pend[i] = 0;
      else if (hit[i]) begin
        if (m_pend[i] && g != i) begin
          drops++;
          lost_ev = 1;
        end else begin
          m_pend[i] = 1;
          m_slot[i] = {m_ts, CH_W'(i), probe_id[i*ID_W +: ID_W], probe_data[i*PROBE_W +: PROBE_W]};
        end
      end else if (g == i) m_pend[i] = 0;
    end
    if (disarm) nstate = 0;
    else if (arm && m_state != 1) nstate = 1;
    else if (m_state == 1 && push && cap_limit != 0 && (m_acc + 1 >= int'(cap_limit))) nstate = 2;
    else nstate = m_state;
    if (!disarm && arm && m_state != 1) m_acc = 0;
    else if (m_state == 1 && push) m_acc++;
    m_state = nstate;
    if (g >= 0) m_rr = g;
    if (clear_sticky) begin
      m_trig = 0; m_ovf = 0; m_lost = 0; m_drop = 0;
    end else begin
      m_trig = m_trig | push;
      m_ovf  = m_ovf | (drops > (lost_ev ? drops : 0)) | ((g >= 0) && !push);
      m_lost = m_lost | lost_ev;
      m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
    end
    if (en) m_ts = m_ts + 1;
    for (int i = 0; i < NUM_CH; i++) m_mpd[i] = mp[i];
  endtask

  always @(posedge clk) model_step();

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (cmp_on) begin
      check("state", 128'(state), 128'(m_state));
      check("triggered_sticky", 128'(triggered_sticky), 128'(m_trig));
      check("overflow_sticky", 128'(overflow_sticky), 128'(m_ovf));
      check("lost_sticky", 128'(lost_sticky), 128'(m_lost));
      check("drop_count", 128'(drop_count), 128'(m_drop));
      check("fifo_count", 128'(fifo_count), 128'(exp_q.size()));
      check("evt_valid", 128'(evt_bus.evt_valid), 128'(exp_q.size() > 0));
      check("evt_data", 128'(evt_bus.evt_data), (exp_q.size() > 0) ? 128'(exp_q[0]) : 128'(0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
  endtask

  task automatic set_probe(input int ch, input logic [PROBE_W-1:0] v);
    probe_data[ch*PROBE_W +: PROBE_W] = v;
  endtask

  task automatic idle_inputs();
    en = 1'b0; arm = 1'b0; disarm = 1'b0; clear_sticky = 1'b0;
    evt_bus.evt_pop = 1'b0; probe_data = '0; cap_limit = '0;
    trig_mask = 32'hFF;
  endtask

  logic [EVT_W-1:0]   rec;
  logic [PROBE_W-1:0] tgl;

  // ---------------- stimulus ----------------
  initial begin
    probe_id = {8'h13, 8'h12, 8'h11, 8'h10};
    ch_enable = '0; trig_mode = '0; trig_value = '0;
    idle_inputs();
    rst_n = 1'b0;
    cyc(2);
    cmp_on = 1'b1;
    check("rst_state", 128'(state), 128'(0));
    check("rst_fifo_count", 128'(fifo_count), 128'(0));
    check("rst_evt_data", 128'(evt_bus.evt_data), 128'(0));
    rst_n = 1'b1;

    // Mode 0 single hit at ts=5
    do_reset();
    ch_enable = 4'b0001; trig_mode = '0; trig_value = 32'hA5;
    pulse_arm();
    en = 1'b1;
    for (int k = 0; k < 20 && m_ts != 5; k++) cyc(1);
    set_probe(0, 32'hA5);
    cyc(1);
    set_probe(0, 32'h0);
    check("t1_valid_early", 128'(evt_bus.evt_valid), 128'(0));
    cyc(1);
    rec = {32'd5, 2'd0, 8'h10, 32'h000000A5};
    check("t1_valid", 128'(evt_bus.evt_valid), 128'(1));
    check("t1_count", 128'(fifo_count), 128'(1));
    check("t1_record", 128'(evt_bus.evt_data), 128'(rec));
    evt_bus.evt_pop = 1'b1; cyc(1);
    cyc(1); evt_bus.evt_pop = 1'b0;   // second pop hits an empty FIFO
    check("pop_empty_count", 128'(fifo_count), 128'(0));
    check("pop_empty_valid", 128'(evt_bus.evt_valid), 128'(0));

    // All channels hit together, twice, then back-to-back re-hits
    do_reset(); idle_inputs();
    ch_enable = 4'hF; trig_mode = '0; trig_value = 32'h3C;
    pulse_arm();
    en = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NUM_CH; i++) set_probe(i, 32'h3C);
      cyc(1);
      probe_data = '0;
      cyc(6);
    end
    check("t2_count", 128'(fifo_count), 128'(8));
    check("t2_drop", 128'(drop_count), 128'(0));
    evt_bus.evt_pop = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("t2_order", 128'(evt_bus.evt_data[PROBE_W+ID_W +: CH_W]), 128'(k % NUM_CH));
      cyc(1);
    end
    evt_bus.evt_pop = 1'b0;
    for (int i = 0; i < NUM_CH; i++) set_probe(i, 32'h3C);
    cyc(2);
    probe_data = '0;
    cyc(6);
    check("t2_lost", 128'(lost_sticky), 128'(1));
    check("t2_lost_drop", 128'(drop_count), 128'(3));
    check("t2_lost_count", 128'(fifo_count), 128'(5));

    // cap_limit=3 with continuous mode-2 toggling, then re-arm
    do_reset(); idle_inputs();
    cap_limit = 16'd3; ch_enable = 4'b0010; trig_mode = 8'b00_00_10_00;
    pulse_arm();
    en = 1'b1;
    tgl = '0;
    for (int k = 0; k < 24; k++) begin
      tgl = tgl ^ 32'h1;
      set_probe(1, tgl);
      arm = (k == 12);
      cyc(1);
      if (k == 11) begin
        check("t3_done", 128'(state), 128'(2));
        check("t3_count", 128'(fifo_count), 128'(4));
      end
    end
    arm = 1'b0;
    check("t3_rearm_done", 128'(state), 128'(2));
    check("t3_rearm_count", 128'(fifo_count), 128'(8));

    // Overflow: 20 granted hits, no pops
    do_reset(); idle_inputs();
    ch_enable = 4'b0010; trig_mode = 8'b00_00_10_00;
    pulse_arm();
    en = 1'b1;
    tgl = '0;
    for (int k = 0; k < 20; k++) begin
      tgl = tgl ^ 32'h1;
      set_probe(1, tgl);
      cyc(1);
    end
    cyc(4);
    check("t4_count", 128'(fifo_count), 128'(16));
    check("t4_ovf", 128'(overflow_sticky), 128'(1));
    check("t4_drop", 128'(drop_count), 128'(4));
    clear_sticky = 1'b1; cyc(1); clear_sticky = 1'b0;
    check("t4_clr_ovf", 128'(overflow_sticky), 128'(0));
    check("t4_clr_drop", 128'(drop_count), 128'(0));
    check("t4_clr_count", 128'(fifo_count), 128'(16));
    // Full FIFO, push and pop in the same cycle
    tgl = tgl ^ 32'h1; set_probe(1, tgl);
    cyc(1);
    evt_bus.evt_pop = 1'b1;
    cyc(1);
    evt_bus.evt_pop = 1'b0;
    check("t5_full_pushpop", 128'(fifo_count), 128'(16));
    check("t5_ovf", 128'(overflow_sticky), 128'(0));

    // Mode 1 rising-from-zero and mode 3 greater-than boundaries
    do_reset(); idle_inputs();
    ch_enable = 4'b0101; trig_mode = 8'b00_11_00_01; trig_value = 32'h40;
    pulse_arm();
    en = 1'b1;
    set_probe(0, 32'h0); set_probe(2, 32'h40); cyc(1);
    set_probe(0, 32'h1); set_probe(2, 32'h3F); cyc(1);
    set_probe(0, 32'h2); set_probe(2, 32'h41); cyc(1);
    probe_data = '0; cyc(4);
    check("t6_count", 128'(fifo_count), 128'(2));
    check("t6_head_ch", 128'(evt_bus.evt_data[PROBE_W+ID_W +: CH_W]), 128'(0));
    check("t6_head_data", 128'(evt_bus.evt_data[PROBE_W-1:0]), 128'(1));
    rst_n = 1'b0; cyc(1);
    check("t6_rst_count", 128'(fifo_count), 128'(0));
    check("t6_rst_valid", 128'(evt_bus.evt_valid), 128'(0));
    check("t6_rst_state", 128'(state), 128'(0));
    check("t6_rst_trig", 128'(triggered_sticky), 128'(0));
    rst_n = 1'b1;

    // Randomized traffic against the model
    idle_inputs();
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 0) begin
        trig_mode  = 8'($urandom);
        ch_enable  = 4'($urandom);
        trig_value = $urandom;
        cap_limit  = 16'($urandom_range(0, 6));
        case ($urandom_range(0, 2))
          0:       trig_mask = 32'h7;
          1:       trig_mask = 32'h3;
          default: trig_mask = 32'hF0;
        endcase
      end
      rst_n        = ($urandom_range(0, 599) != 0);
      en           = ($urandom_range(0, 9) != 0);
      arm          = ($urandom_range(0, 29) == 0);
      disarm       = ($urandom_range(0, 119) == 0);
      clear_sticky = ($urandom_range(0, 199) == 0);
      evt_bus.evt_pop = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NUM_CH; i++) set_probe(i, $urandom);
      cyc(1);
    end
    idle_inputs();
    rst_n = 1'b1;
    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
